// File: rtl/uart_rx_pkt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkt_pkg
// Description : Shared definitions for the UART packet receiver: FSM state
//               encodings, frame header constant, error codes and a constant
//               width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_pkt_pkg;

    // Frame receiver states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LEN     = 3'd1,
        ST_PAYLOAD = 3'd2,
        ST_CHECK   = 3'd3,
        ST_READY   = 3'd4
    } state_t;

    // Start-of-frame marker
    localparam logic [7:0] c_header = 8'hA5;

    // Error codes reported on errCode
    localparam logic [1:0] c_err_none    = 2'b00;
    localparam logic [1:0] c_err_len     = 2'b01;
    localparam logic [1:0] c_err_timeout = 2'b10;
    localparam logic [1:0] c_err_chk     = 2'b11;

    // Bits needed to index 'value' entries (equals $clog2 for value > 1,
    // never returns 0 so vectors built from it stay legal)
    function automatic int width_of(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage : uart_rx_pkt_pkg
`default_nettype wire

// File: rtl/uart_rx_pkt_buf.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkt_buf
// Description : Payload buffer, MAX_PAYLOAD entries of DATAWIDTH_BUS bits.
//               Synchronous write, asynchronous read; out-of-range reads
//               return zero and out-of-range writes are discarded.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_pkt_buf
    import uart_rx_pkt_pkg::*;
#(
    parameter int DATAWIDTH_BUS = 8,
    parameter int MAX_PAYLOAD   = 16
) (
    input  logic                     clk,
    input  logic                     i_wr_en,
    input  logic [4:0]               i_wr_addr,
    input  logic [DATAWIDTH_BUS-1:0] i_wr_data,
    input  logic [4:0]               i_rd_addr,
    output logic [DATAWIDTH_BUS-1:0] o_rd_data
);

    localparam int              c_aw    = width_of(MAX_PAYLOAD);
    localparam logic [5:0]      c_depth = 6'(MAX_PAYLOAD);

    logic [DATAWIDTH_BUS-1:0] r_mem [MAX_PAYLOAD];
    logic                     w_wr_in_range;
    logic                     w_rd_in_range;

    assign w_wr_in_range = ({1'b0, i_wr_addr} < c_depth);
    assign w_rd_in_range = ({1'b0, i_rd_addr} < c_depth);

    // Store one payload byte per write strobe
    always_ff @(posedge clk) begin
        if (i_wr_en && w_wr_in_range) begin
            r_mem[i_wr_addr[c_aw-1:0]] <= i_wr_data;
        end
    end

    assign o_rd_data = w_rd_in_range ? r_mem[i_rd_addr[c_aw-1:0]] : '0;

endmodule : uart_rx_pkt_buf
`default_nettype wire

// File: rtl/uart_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_pkt_ctrl
// Description : Frame assembler behind a UART byte receiver. Accepts
//               A5, LEN, LEN payload bytes [, CHK], validates the frame and
//               holds it for the consumer until frameAck. Reports bad length,
//               inter-byte timeout and checksum errors, and flags bytes
//               dropped while a frame is held.
//               Optional feature macro: UART_RX_PKT_CHECKSUM_EN
//               (defined: trailing XOR checksum byte is expected and checked).
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_pkt_ctrl
    import uart_rx_pkt_pkg::*;
#(
    parameter int DATAWIDTH_BUS  = 8,
    parameter int MAX_PAYLOAD    = 16,
    parameter int TIMEOUT_CYCLES = 8680
) (
    input  logic                     UART_RX_PKT_CLOCK_50,
    input  logic                     UART_RX_PKT_RESET_InHigh,
    input  logic                     UART_RX_PKT_newData_In,
    input  logic [DATAWIDTH_BUS-1:0] UART_RX_PKT_data_In,
    input  logic                     UART_RX_PKT_frameAck_In,
    input  logic [4:0]               UART_RX_PKT_rdAddr_In,
    output logic                     UART_RX_PKT_frameReady_Out,
    output logic [4:0]               UART_RX_PKT_frameLen_Out,
    output logic [DATAWIDTH_BUS-1:0] UART_RX_PKT_rdData_Out,
    output logic                     UART_RX_PKT_error_Out,
    output logic [1:0]               UART_RX_PKT_errCode_Out,
    output logic                     UART_RX_PKT_overrun_Out
);

    localparam int                       c_to_w     = width_of(TIMEOUT_CYCLES);
    localparam logic [c_to_w-1:0]        c_to_limit = c_to_w'(TIMEOUT_CYCLES - 1);
    localparam logic [DATAWIDTH_BUS-1:0] c_hdr_word = DATAWIDTH_BUS'(c_header);
    localparam logic [DATAWIDTH_BUS-1:0] c_max_len  = DATAWIDTH_BUS'(MAX_PAYLOAD);

    // Registered state
    state_t              r_state;
    logic [4:0]          r_len;
    logic [4:0]          r_idx;
    logic [c_to_w-1:0]   r_to_cnt;
    logic                r_err;
    logic [1:0]          r_err_code;
    logic                r_ovr;
`ifdef UART_RX_PKT_CHECKSUM_EN
    logic [7:0]          r_chk;
    logic                w_chk_ok;
`endif

    // Next-state and control decode
    state_t              w_state_nxt;
    logic                w_strobe;
    logic                w_is_hdr;
    logic                w_len_bad;
    logic                w_last_byte;
    logic                w_active;
    logic                w_to_hit;
    logic                w_wr_en;
    logic                w_len_ld;
    logic                w_idx_inc;
    logic                w_err_set;
    logic [1:0]          w_err_code;
    logic                w_ovr_set;
    logic                w_ready;
    logic                w_rd_valid;
    logic [DATAWIDTH_BUS-1:0] w_buf_rd;

    assign w_strobe    = UART_RX_PKT_newData_In;
    assign w_is_hdr    = (UART_RX_PKT_data_In == c_hdr_word);
    assign w_len_bad   = (UART_RX_PKT_data_In == '0) || (UART_RX_PKT_data_In > c_max_len);
    assign w_last_byte = (r_idx == (r_len - 5'd1));
    assign w_active    = (r_state == ST_LEN) || (r_state == ST_PAYLOAD) || (r_state == ST_CHECK);
    // A strobe on the limit cycle wins over the timeout
    assign w_to_hit    = w_active && !w_strobe && (r_to_cnt == c_to_limit);
`ifdef UART_RX_PKT_CHECKSUM_EN
    assign w_chk_ok    = (UART_RX_PKT_data_In[7:0] == r_chk);
`endif

    // State register
    always_ff @(posedge UART_RX_PKT_CLOCK_50 or posedge UART_RX_PKT_RESET_InHigh) begin
        if (UART_RX_PKT_RESET_InHigh) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic and per-cycle control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_wr_en     = 1'b0;
        w_len_ld    = 1'b0;
        w_idx_inc   = 1'b0;
        w_err_set   = 1'b0;
        w_err_code  = c_err_none;
        w_ovr_set   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_strobe && w_is_hdr) begin
                    w_state_nxt = ST_LEN;
                end
            end
            ST_LEN: begin
                if (w_strobe) begin
                    if (w_len_bad) begin
                        w_err_set   = 1'b1;
                        w_err_code  = c_err_len;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_len_ld    = 1'b1;
                        w_state_nxt = ST_PAYLOAD;
                    end
                end else if (w_to_hit) begin
                    w_err_set   = 1'b1;
                    w_err_code  = c_err_timeout;
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_PAYLOAD: begin
                if (w_strobe) begin
                    w_wr_en   = 1'b1;
                    w_idx_inc = 1'b1;
                    if (w_last_byte) begin
`ifdef UART_RX_PKT_CHECKSUM_EN
                        w_state_nxt = ST_CHECK;
`else
                        w_state_nxt = ST_READY;
`endif
                    end
                end else if (w_to_hit) begin
                    w_err_set   = 1'b1;
                    w_err_code  = c_err_timeout;
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef UART_RX_PKT_CHECKSUM_EN
            ST_CHECK: begin
                if (w_strobe) begin
                    if (w_chk_ok) begin
                        w_state_nxt = ST_READY;
                    end else begin
                        w_err_set   = 1'b1;
                        w_err_code  = c_err_chk;
                        w_state_nxt = ST_IDLE;
                    end
                end else if (w_to_hit) begin
                    w_err_set   = 1'b1;
                    w_err_code  = c_err_timeout;
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            ST_READY: begin
                // The held frame is never overwritten; any byte is dropped
                if (w_strobe) begin
                    w_ovr_set = 1'b1;
                end
                if (UART_RX_PKT_frameAck_In) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Length, index, timeout counter and status pulses
    always_ff @(posedge UART_RX_PKT_CLOCK_50 or posedge UART_RX_PKT_RESET_InHigh) begin
        if (UART_RX_PKT_RESET_InHigh) begin
            r_len      <= '0;
            r_idx      <= '0;
            r_to_cnt   <= '0;
            r_err      <= 1'b0;
            r_err_code <= c_err_none;
            r_ovr      <= 1'b0;
        end else begin
            r_err <= w_err_set;
            r_ovr <= w_ovr_set;
            if (w_err_set) begin
                r_err_code <= w_err_code;
            end
            if (w_len_ld) begin
                r_len <= UART_RX_PKT_data_In[4:0];
            end
            if (w_len_ld) begin
                r_idx <= '0;
            end else if (w_idx_inc) begin
                r_idx <= r_idx + 5'd1;
            end
            // Counter only runs inside a frame and is cleared before it can wrap
            if (w_active && !w_strobe && !w_to_hit) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

`ifdef UART_RX_PKT_CHECKSUM_EN
    // Running XOR of LEN and payload bytes, restarted every frame
    always_ff @(posedge UART_RX_PKT_CLOCK_50 or posedge UART_RX_PKT_RESET_InHigh) begin
        if (UART_RX_PKT_RESET_InHigh) begin
            r_chk <= '0;
        end else begin
            case (r_state)
                ST_IDLE:    r_chk <= '0;
                ST_LEN:     if (w_strobe) r_chk <= UART_RX_PKT_data_In[7:0];
                ST_PAYLOAD: if (w_strobe) r_chk <= r_chk ^ UART_RX_PKT_data_In[7:0];
                default:    r_chk <= r_chk;
            endcase
        end
    end
`endif

    uart_rx_pkt_buf #(
        .DATAWIDTH_BUS (DATAWIDTH_BUS),
        .MAX_PAYLOAD   (MAX_PAYLOAD)
    ) u_buf (
        .clk       (UART_RX_PKT_CLOCK_50),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_idx),
        .i_wr_data (UART_RX_PKT_data_In),
        .i_rd_addr (UART_RX_PKT_rdAddr_In),
        .o_rd_data (w_buf_rd)
    );

    assign w_ready    = (r_state == ST_READY);
    assign w_rd_valid = w_ready && (UART_RX_PKT_rdAddr_In < r_len);

    assign UART_RX_PKT_frameReady_Out = w_ready;
    assign UART_RX_PKT_frameLen_Out   = w_ready ? r_len : 5'd0;
    assign UART_RX_PKT_rdData_Out     = w_rd_valid ? w_buf_rd : '0;
    assign UART_RX_PKT_error_Out      = r_err;
    assign UART_RX_PKT_errCode_Out    = r_err_code;
    assign UART_RX_PKT_overrun_Out    = r_ovr;

endmodule : uart_rx_pkt_ctrl
`default_nettype wire

// File: tb/tb_uart_rx_pkt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_pkt_ctrl
// Description : Self-checking bench for uart_rx_pkt_ctrl. Stimulus pushes the
//               expected events (frame ready, error, overrun) into a queue; a
//               monitor pops and compares whenever the DUT raises one.
//               Follows UART_RX_PKT_CHECKSUM_EN to add CHK bytes and cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_pkt_ctrl;

    localparam int         c_to    = 40;
    localparam logic [1:0] c_k_rdy = 2'd0;
    localparam logic [1:0] c_k_err = 2'd1;
    localparam logic [1:0] c_k_ovr = 2'd2;

    typedef struct packed {
        logic [1:0] kind;
        logic [4:0] val;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       nd  = 1'b0;
    logic [7:0] din = 8'h00;
    logic       ack = 1'b0;
    logic [4:0] rda = 5'd0;
    logic       rdy;
    logic [4:0] flen;
    logic [7:0] rdd;
    logic       err;
    logic [1:0] ecode;
    logic       ovr;

    exp_t       exp_q[$];
    int         checks   = 0;
    int         failures = 0;
    logic       prev_rdy = 1'b0;
    logic [7:0] pl [32];

    uart_rx_pkt_ctrl #(
        .DATAWIDTH_BUS  (8),
        .MAX_PAYLOAD    (16),
        .TIMEOUT_CYCLES (c_to)
    ) dut (
        .UART_RX_PKT_CLOCK_50       (clk),
        .UART_RX_PKT_RESET_InHigh   (rst),
        .UART_RX_PKT_newData_In     (nd),
        .UART_RX_PKT_data_In        (din),
        .UART_RX_PKT_frameAck_In    (ack),
        .UART_RX_PKT_rdAddr_In      (rda),
        .UART_RX_PKT_frameReady_Out (rdy),
        .UART_RX_PKT_frameLen_Out   (flen),
        .UART_RX_PKT_rdData_Out     (rdd),
        .UART_RX_PKT_error_Out      (err),
        .UART_RX_PKT_errCode_Out    (ecode),
        .UART_RX_PKT_overrun_Out    (ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_exp(input logic [1:0] k, input logic [4:0] v);
        exp_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic mon_event(input logic [1:0] k, input logic [4:0] v);
        exp_t e;
        checks++;
        if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event kind=%0d val=%0h required=none", k, v);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.val != v) begin
                failures++;
                $display("FAIL event actual kind=%0d val=%0h required kind=%0d val=%0h",
                         k, v, e.kind, e.val);
            end
        end
    endtask

    // Monitor: sample away from the active edge, score every event the DUT shows
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (err)             mon_event(c_k_err, {3'b000, ecode});
                if (ovr)             mon_event(c_k_ovr, 5'd0);
                if (rdy && !prev_rdy) mon_event(c_k_rdy, flen);
            end
            prev_rdy = rdy;
        end
    end

    // Caller sits 1 time unit after a rising edge; byte is sampled on the next edge
    task automatic send_byte(input logic [7:0] b);
        nd  = 1'b1;
        din = b;
        @(posedge clk);
        #1;
        nd  = 1'b0;
        din = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_frame(input int n);
        logic [7:0] x;
        x = 8'(n);
        send_byte(8'hA5);
        send_byte(8'(n));
        for (int i = 0; i < n; i++) begin
            send_byte(pl[i]);
            x = x ^ pl[i];
        end
`ifdef UART_RX_PKT_CHECKSUM_EN
        send_byte(x);
`endif
    endtask

    task automatic rd_chk(input string name, input logic [4:0] a, input logic [7:0] e);
        rda = a;
        #1;
        chk(name, rdd, e);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        @(posedge clk);
        #1;
        ack = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 50; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        chk(name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        @(posedge clk);
        #1;
        chk("rst_ready",   rdy,   0);
        chk("rst_len",     flen,  0);
        chk("rst_err",     err,   0);
        chk("rst_errcode", ecode, 0);
        chk("rst_ovr",     ovr,   0);
        chk("rst_rddata",  rdd,   0);
        rst = 1'b0;
        idle(2);

        // Non-header bytes in IDLE are ignored
        send_byte(8'h11);
        send_byte(8'h03);
        idle(3);
        chk("noise_ready", rdy, 0);

        // Basic 3-byte frame
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        push_exp(c_k_rdy, 5'd3);
        send_frame(3);
        chk("f1_ready", rdy, 1);
        chk("f1_len", flen, 3);
        rd_chk("f1_rd0", 5'd0, 8'h11);
        rd_chk("f1_rd1", 5'd1, 8'h22);
        rd_chk("f1_rd2", 5'd2, 8'h33);
        rd_chk("f1_rd3", 5'd3, 8'h00);
        rd_chk("f1_rd31", 5'd31, 8'h00);
        rda = 5'd0;
        do_ack();
        chk("f1_ack_ready", rdy, 0);
        rd_chk("f1_after_ack_rd0", 5'd0, 8'h00);
        wait_drain("f1_drain");

`ifdef UART_RX_PKT_CHECKSUM_EN
        // Wrong checksum
        push_exp(c_k_err, 5'd3);
        send_byte(8'hA5); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        send_byte(8'hFF);
        idle(2);
        chk("badchk_ready", rdy, 0);
        wait_drain("badchk_drain");
`endif

        // Length 0 and length 17 rejected
        push_exp(c_k_err, 5'd1);
        send_byte(8'hA5); send_byte(8'h00);
        wait_drain("len0_drain");
        push_exp(c_k_err, 5'd1);
        send_byte(8'hA5); send_byte(8'h11);
        wait_drain("len17_drain");
        idle(3);
        chk("errcode_held", ecode, 1);
        chk("err_is_pulse", err, 0);

        // Maximum length frame
        for (int i = 0; i < 16; i++) pl[i] = 8'h40 + 8'(i);
        push_exp(c_k_rdy, 5'd16);
        send_frame(16);
        chk("f16_len", flen, 16);
        rd_chk("f16_rd15", 5'd15, 8'h4F);
        rd_chk("f16_rd16", 5'd16, 8'h00);
        rda = 5'd0;
        do_ack();
        wait_drain("f16_drain");

        // Timeout after c_to silent cycles
        push_exp(c_k_err, 5'd2);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h44);
        idle(c_to - 1);
        chk("to_early", err, 0);
        idle(1);
        chk("to_pulse", err, 1);
        chk("to_code", ecode, 2);
        wait_drain("to_drain");

        // Strobe exactly on the limit cycle prevents the timeout
        push_exp(c_k_rdy, 5'd2);
        send_byte(8'hA5); send_byte(8'h02); send_byte(8'h44);
        idle(c_to - 1);
        send_byte(8'h55);
`ifdef UART_RX_PKT_CHECKSUM_EN
        send_byte(8'h13);
`endif
        chk("limit_ready", rdy, 1);
        rd_chk("limit_rd0", 5'd0, 8'h44);
        rd_chk("limit_rd1", 5'd1, 8'h55);
        rda = 5'd0;
        do_ack();
        wait_drain("limit_drain");

        // Byte coincident with frameAck is dropped; next frame accepted
        pl[0] = 8'h5A;
        push_exp(c_k_rdy, 5'd1);
        send_frame(1);
        push_exp(c_k_ovr, 5'd0);
        nd = 1'b1; din = 8'hA5; ack = 1'b1;
        @(posedge clk);
        #1;
        nd = 1'b0; din = 8'h00; ack = 1'b0;
        chk("ovr_ready", rdy, 0);
        chk("ovr_pulse", ovr, 1);
        pl[0] = 8'h7E;
        push_exp(c_k_rdy, 5'd1);
        send_frame(1);
        chk("after_ovr_ready", rdy, 1);
        rd_chk("after_ovr_rd0", 5'd0, 8'h7E);
        do_ack();
        wait_drain("ovr_drain");

        // Reset mid-frame discards it
        send_byte(8'hA5); send_byte(8'h03); send_byte(8'h11);
        rst = 1'b1;
        #2;
        chk("midrst_ready",   rdy,   0);
        chk("midrst_len",     flen,  0);
        chk("midrst_err",     err,   0);
        chk("midrst_errcode", ecode, 0);
        chk("midrst_ovr",     ovr,   0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        pl[0] = 8'h11; pl[1] = 8'h22; pl[2] = 8'h33;
        push_exp(c_k_rdy, 5'd3);
        send_frame(3);
        chk("postrst_ready", rdy, 1);
        rd_chk("postrst_rd2", 5'd2, 8'h33);
        wait_drain("postrst_drain");

        // Reset while a frame is held
        rst = 1'b1;
        #2;
        chk("readyrst_ready", rdy, 0);
        chk("readyrst_rd", rdd, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);

        chk("queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx_pkt_ctrl
`default_nettype wire
